uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 2..65535.
REQ-003 SHALL provide parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 p_data  input  DATA_W  parallel data word, sampled on acceptance.
REQ-008 data_valid  input  1  request to transmit p_data.
REQ-009 par_en  input  1  1 = parity bit inserted; sampled on acceptance.
REQ-010 par_type  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
REQ-011 tx_out  output  1  registered serial line; idle high.
REQ-012 busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
REQ-013 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; other encodings SHALL return to IDLE.
REQ-015 Acceptance: data_valid=1 while state=IDLE; p_data, par_en, par_type latched in that cycle; data_valid ignored in all other states.
REQ-016 Baud counter SHALL count 0..CLKS_PER_BIT-1 per bit; bit ends when counter = CLKS_PER_BIT-1, then clears to 0.
REQ-017 Cycle after acceptance: state=START, tx_out=0, busy=1.
REQ-018 DATA: DATA_W bits, LSB first, bit index counter width clog2(DATA_W).
REQ-019 After last data bit: PARITY if latched par_en=1, else STOP.
REQ-020 Parity bit = XOR of latched data bits, inverted when latched par_type=1.
REQ-021 STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
REQ-022 Frame length SHALL be exactly (1+DATA_W+par_en+STOP_BITS)*CLKS_PER_BIT cycles of busy=1.
REQ-023 done SHALL be 1 for exactly one cycle: the first IDLE cycle after STOP; busy=0 in that cycle.
REQ-024 Back-to-back: data_valid=1 in the done cycle SHALL be accepted; next START follows with no extra idle cycle.
REQ-025 tx_out SHALL change only at bit boundaries; no glitches (registered output).
REQ-026 Changes to p_data, par_en, par_type after acceptance SHALL NOT affect the current frame.

Reset
REQ-027 rst=1 SHALL force immediately: state=IDLE, tx_out=1, busy=0, done=0, baud and bit counters 0, latched data 0.
REQ-028 Reset mid-frame SHALL abort the frame with no done pulse; first acceptance after rst release starts a full new frame.
REQ-029 data_valid held high during reset SHALL be accepted on the first clk edge after rst falls.

Verification (DATA_W=8, CLKS_PER_BIT=4 unless stated)
REQ-030 0xA5, par_en=0, STOP_BITS=1 -> tx_out 0,1,0,1,0,0,1,0,1,1, 4 cycles each; busy=1 for 40 cycles; done pulse at cycle 41.
REQ-031 0x07, par_en=1, par_type=0 -> parity bit 1; par_type=1 -> parity bit 0; busy=1 for 44 cycles.
REQ-032 STOP_BITS=2, 0xFF, par_en=0 -> tx_out high for 8 stop cycles; busy=1 for 44 cycles.
REQ-033 data_valid pulsed with 0x3C at cycle 10 of a 0x81 frame -> ignored; only 0x81 transmitted.
REQ-034 rst asserted at cycle 20 of a frame -> tx_out=1, busy=0 same cycle, no done; next 0x55 frame correct.
REQ-035 data_valid held high with 0x11 then 0x22 -> second frame START immediately follows the done cycle; both frames bit-exact.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// Parallel-in handshake and serial status bundle for uart_tx_param.
// master drives the request side, slave is the transmitter.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] p_data;
    logic              data_valid;
    logic              par_en;
    logic              par_type;
    logic              tx_out;
    logic              busy;
    logic              done;

    modport master (
        output p_data, data_valid, par_en, par_type,
        input  tx_out, busy, done
    );

    modport slave (
        input  p_data, data_valid, par_en, par_type,
        output tx_out, busy, done
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, DATA_W bits LSB first,
// optional even/odd parity, STOP_BITS stop bits, registered line.
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_param_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BAUD_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [DATA_W-1:0] data_q;
    logic              pe_q;
    logic              pt_q;
    logic              tx_q;
    logic              tx_d;
    logic              done_q;
    logic              done_d;
    logic              accept;
    logic              bit_end;

    assign accept  = (state == IDLE) && bus.data_valid;
    assign bit_end = (cnt_q == BAUD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            pe_q   <= 1'b0;
            pt_q   <= 1'b0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= nxt;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            tx_q   <= tx_d;
            done_q <= done_d;
            if (accept) begin
                data_q <= bus.p_data;
                pe_q   <= bus.par_en;
                pt_q   <= bus.par_type;
            end
        end
    end

    // idx_q counts data bits in DATA and stop bits in STOP
    always_comb begin
        nxt   = state;
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (bus.data_valid) nxt = START;
            end
            START: begin
                if (bit_end) nxt = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        nxt   = pe_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) nxt = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        nxt   = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                nxt   = IDLE;
                cnt_d = '0;
                idx_d = '0;
            end
        endcase
    end

    // line value is computed for the next state so tx_q stays registered
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state == STOP) && (nxt == IDLE);
        unique case (nxt)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[idx_d];
            PARITY:  tx_d = (^data_q) ^ pt_q;
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 1- and 2-stop instances at
// CLKS_PER_BIT=4, table-driven frames plus reset and back-to-back cases.
module tb_uart_tx_param;
    logic clk;
    logic rst;
    bit   sel;
    int   checks;
    int   failures;

    uart_tx_param_if #(.DATA_W(8)) ifa ();
    uart_tx_param_if #(.DATA_W(8)) ifb ();

    uart_tx_param #(
        .DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    uart_tx_param #(
        .DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         pe;
        bit         pt;
        bit         s2;
        string      frame;
        int         blen;
        int         inj;
    } vec_t;

    vec_t tv[7];

    task automatic set_tv(int i, logic [7:0] d, bit pe, bit pt,
                          bit s2, string f, int blen, int inj);
        tv[i].data  = d;
        tv[i].pe    = pe;
        tv[i].pt    = pt;
        tv[i].s2    = s2;
        tv[i].frame = f;
        tv[i].blen  = blen;
        tv[i].inj   = inj;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int tx_now();
        return sel ? int'(ifb.tx_out) : int'(ifa.tx_out);
    endfunction

    function automatic int busy_now();
        return sel ? int'(ifb.busy) : int'(ifa.busy);
    endfunction

    function automatic int done_now();
        return sel ? int'(ifb.done) : int'(ifa.done);
    endfunction

    task automatic drive(bit v, logic [7:0] d, bit pe, bit pt);
        if (sel) begin
            ifa.data_valid = 1'b0;
            ifb.data_valid = v;
            ifb.p_data     = d;
            ifb.par_en     = pe;
            ifb.par_type   = pt;
        end else begin
            ifb.data_valid = 1'b0;
            ifa.data_valid = v;
            ifa.p_data     = d;
            ifa.par_en     = pe;
            ifa.par_type   = pt;
        end
    endtask

    // entered at the negedge of the first START cycle
    task automatic check_frame(string f, int blen, int inj);
        int bc;
        int k;
        bc = 0;
        for (int b = 0; b < f.len(); b++) begin
            for (int c = 0; c < 4; c++) begin
                k = b * 4 + c;
                chk($sformatf("tx_bit%0d_cyc%0d", b, c), tx_now(),
                    (f.getc(b) == 8'h31) ? 1 : 0);
                bc += busy_now();
                if (inj >= 0 && k == inj)
                    drive(1'b1, 8'h3C, 1'b1, 1'b0);
                else if (inj >= 0 && k == inj + 1)
                    drive(1'b0, 8'h3C, 1'b1, 1'b0);
                @(negedge clk);
            end
        end
        chk("busy_len", bc, blen);
        chk("done_pulse", done_now(), 1);
        chk("busy_at_done", busy_now(), 0);
        chk("tx_idle_at_done", tx_now(), 1);
    endtask

    task automatic run_vec(int i);
        sel = tv[i].s2;
        drive(1'b1, tv[i].data, tv[i].pe, tv[i].pt);
        @(negedge clk);
        drive(1'b0, ~tv[i].data, ~tv[i].pe, ~tv[i].pt);
        check_frame(tv[i].frame, tv[i].blen, tv[i].inj);
        @(negedge clk);
        chk($sformatf("done_clear_v%0d", i), done_now(), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        rst      = 1'b1;
        ifa.data_valid = 1'b0;
        ifa.p_data     = '0;
        ifa.par_en     = 1'b0;
        ifa.par_type   = 1'b0;
        ifb.data_valid = 1'b0;
        ifb.p_data     = '0;
        ifb.par_en     = 1'b0;
        ifb.par_type   = 1'b0;

        set_tv(0, 8'hA5, 0, 0, 0, "0101001011", 40, -1);
        set_tv(1, 8'h07, 1, 0, 0, "01110000011", 44, -1);
        set_tv(2, 8'h07, 1, 1, 0, "01110000001", 44, -1);
        set_tv(3, 8'h3C, 1, 0, 0, "00011110001", 44, -1);
        set_tv(4, 8'hFF, 0, 0, 1, "01111111111", 44, -1);
        set_tv(5, 8'h81, 0, 0, 0, "0100000011", 40, 10);
        set_tv(6, 8'h3C, 1, 1, 1, "000111100111", 48, -1);

        repeat (2) @(negedge clk);
        chk("rst_tx_a", int'(ifa.tx_out), 1);
        chk("rst_busy_a", int'(ifa.busy), 0);
        chk("rst_done_a", int'(ifa.done), 0);
        chk("rst_tx_b", int'(ifb.tx_out), 1);
        chk("rst_busy_b", int'(ifb.busy), 0);
        chk("rst_done_b", int'(ifb.done), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i);

        // reset in the middle of a frame, data_valid held through reset
        sel = 1'b0;
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'hA5, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        chk("pre_rst_busy", busy_now(), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", tx_now(), 1);
        chk("midrst_busy", busy_now(), 0);
        chk("midrst_done", done_now(), 0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_done", done_now(), 0);
            chk("rst_hold_busy", busy_now(), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        drive(1'b0, 8'hAA, 1'b1, 1'b1);
        check_frame("0101010101", 40, -1);
        @(negedge clk);
        chk("done_clear_55", done_now(), 0);

        // back-to-back frames with data_valid held high
        sel = 1'b0;
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        check_frame("0100010001", 40, -1);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check_frame("0010001001", 40, -1);
        @(negedge clk);
        chk("done_clear_b2b", done_now(), 0);
        chk("idle_tx_b2b", tx_now(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
